core_control_ldm_seq: RTL

- Parametrised load/store-multiple sequencer for the core control path; replaces the fixed 16-register LDM/STM walk with a generic register-list engine.
- Takes a register bitmap, base address, addressing mode and direction, then issues one word access per set bit over the core memory handshake.
- Returns register writebacks for loads and the final base value for base writeback.
- Reports a fault and aborts cleanly on a memory fault.

---
 rtl/core_control_ldm_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/core_control_ldm_seq.sv
// Load/store-multiple sequencer: walks a register bitmap lowest-first and
// issues one word access per set bit over the core memory handshake.
// Optional macro CORE_LDM_PIPELINE_EN: when defined, back-to-back accesses skip
// the ISSUE bubble by re-issuing in the same cycle as a clean mem_ready.
module core_control_ldm_seq #(
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned ADDR_W   = 30,
   localparam int unsigned RW      = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [NUM_REGS-1:0] list,
   input  logic [ADDR_W-1:0]   base,
   input  logic                increment,
   input  logic                pre_index,
   input  logic                load,
   input  logic                user,
   input  logic                mem_ready,
   input  logic                mem_fault,
   input  logic [31:0]         mem_data_rd,
   input  logic [31:0]         rd_value,
   output logic                busy,
   output logic                done,
   output logic                fault,
   output logic [RW-1:0]       reg_sel,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_start,
   output logic                mem_write,
   output logic                mem_user,
   output logic [31:0]         mem_data_wr,
   output logic                wb_en,
   output logic [RW-1:0]       wb_reg,
   output logic [31:0]         wb_value,
   output logic [ADDR_W-1:0]   base_wb
);

   localparam int unsigned CW = $clog2(NUM_REGS + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t              state, state_nxt;
   logic [NUM_REGS-1:0] list_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W-1:0]   base_wb_q;
   logic                fault_q;
   logic                write_q;
   logic                user_q;

   logic [CW-1:0]       cnt;
   logic [ADDR_W-1:0]   cnt_a;
   logic [ADDR_W-1:0]   start_addr;
   logic [RW-1:0]       cur_sel;
   logic [NUM_REGS-1:0] list_rest;
   logic                last;
   logic                ready_ok;
   logic                pipe_go;

   // Index of the lowest set bit (0 when the vector is empty).
   function automatic logic [RW-1:0] lowest(input logic [NUM_REGS-1:0] v);
      lowest = '0;
      for (int i = int'(NUM_REGS) - 1; i >= 0; i--) begin
         if (v[i]) lowest = RW'(i);
      end
   endfunction

   // Number of registers in the requested list.
   always_comb begin
      cnt = '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         cnt = cnt + CW'(list[i]);
      end
   end

   assign cnt_a = ADDR_W'(cnt);

   // Lowest register always maps to the lowest address of the block.
   always_comb begin
      case ({increment, pre_index})
         2'b10:   start_addr = base;
         2'b11:   start_addr = base + ADDR_W'(1);
         2'b00:   start_addr = base - cnt_a + ADDR_W'(1);
         default: start_addr = base - cnt_a;
      endcase
   end

   assign cur_sel   = lowest(list_q);
   assign list_rest = list_q & ~(NUM_REGS'(1) << cur_sel);
   assign last      = (list_rest == '0);
   assign ready_ok  = (state == WAIT) && mem_ready && !mem_fault;

`ifdef CORE_LDM_PIPELINE_EN
   assign pipe_go = ready_ok && !last;
`else
   assign pipe_go = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = (cnt == '0) ? DONE : ISSUE;
         ISSUE: state_nxt = WAIT;
         WAIT:  if (mem_ready) begin
                   if (mem_fault || last) state_nxt = DONE;
                   else if (pipe_go)      state_nxt = WAIT;
                   else                   state_nxt = ISSUE;
                end
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch, remaining-list walk and address advance.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         list_q    <= '0;
         addr_q    <= '0;
         base_wb_q <= '0;
         fault_q   <= 1'b0;
         write_q   <= 1'b0;
         user_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               list_q    <= list;
               addr_q    <= start_addr;
               base_wb_q <= increment ? (base + cnt_a) : (base - cnt_a);
               fault_q   <= 1'b0;
               write_q   <= !load;
               user_q    <= user;
            end
            WAIT: if (mem_ready) begin
               if (mem_fault) begin
                  list_q  <= '0;
                  fault_q <= 1'b1;
               end else begin
                  list_q <= list_rest;
                  addr_q <= addr_q + ADDR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from state and latched request.
   assign busy        = (state == ISSUE) || (state == WAIT);
   assign done        = (state == DONE);
   assign fault       = done && fault_q;
   assign reg_sel     = pipe_go ? lowest(list_rest) : cur_sel;
   assign mem_addr    = pipe_go ? (addr_q + ADDR_W'(1)) : addr_q;
   assign mem_start   = (state == ISSUE) || pipe_go;
   assign mem_write   = busy && write_q;
   assign mem_user    = busy && user_q;
   assign mem_data_wr = (busy && write_q) ? rd_value : 32'h0;
   assign wb_en       = ready_ok && !write_q;
   assign wb_reg      = wb_en ? cur_sel : '0;
   assign wb_value    = wb_en ? mem_data_rd : 32'h0;
   assign base_wb     = base_wb_q;

endmodule
